// File: rtl/mem_line_responder.sv
// Main-memory line responder for the L2-to-memory port. It answers each address
// strobe with a fixed-latency, critical-word-first burst of 64-bit beats.
module mem_line_responder #(
  parameter int LINE_BEATS    = 8,
  parameter int MEM_WORDS     = 4096,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        addrstb,
  input  logic        we,
  input  logic [31:0] addr,
  inout  wire  [63:0] data,
  output logic        stb,
  output logic        busy,
  output logic        req_drop,
  output logic [15:0] rd_lines,
  output logic [15:0] wr_lines
);

  localparam int BEAT_W  = $clog2(LINE_BEATS);
  localparam int LINES   = MEM_WORDS / LINE_BEATS;
  localparam int LINE_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int WORD_W  = LINE_W + BEAT_W;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_BURST
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [LAT_W-1:0]  r_lat, w_lat_nxt;
  logic [BEAT_W-1:0] r_beat, w_beat_nxt;
  logic [BEAT_W-1:0] r_start;
  logic [LINE_W-1:0] r_line;
  logic              r_drop;
  logic [15:0]       r_rd_lines, r_wr_lines;

  logic              w_accept, w_last, w_drive;
  logic              w_rd_done, w_wr_done;
  logic [BEAT_W-1:0] w_idx;
  logic [WORD_W-1:0] w_word;
  logic [63:0]       w_rdata;

  // Words are stored XORed with their power-up pattern, so the all-zero initial
  // array decodes to {i, ~i} without any load sequence.
  logic [63:0] r_mem [MEM_WORDS] = '{default: '0};

  function automatic logic [63:0] init_word(input logic [WORD_W-1:0] idx);
    logic [31:0] w;
    w = 32'(idx);
    return {w, ~w};
  endfunction

  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
    return LINE_W'((a >> (3 + BEAT_W)) % 32'(LINES));
  endfunction

  assign w_idx   = r_start + r_beat;
  assign w_word  = {r_line, w_idx};
  assign w_rdata = r_mem[w_word] ^ init_word(w_word);
  assign w_last  = (r_beat == BEAT_W'(LINE_BEATS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat;
    w_beat_nxt  = r_beat;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (addrstb) begin
          w_accept    = 1'b1;
          w_beat_nxt  = '0;
          w_lat_nxt   = we ? LAT_W'(WRITE_LATENCY - 1) : LAT_W'(READ_LATENCY - 1);
          w_state_nxt = we ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_lat == '0) w_state_nxt = RD_BURST;
        else             w_lat_nxt   = r_lat - 1'b1;
      end
      WR_WAIT: begin
        if (r_lat == '0) w_state_nxt = WR_BURST;
        else             w_lat_nxt   = r_lat - 1'b1;
      end
      RD_BURST, WR_BURST: begin
        w_beat_nxt = r_beat + 1'b1;
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rd_done = (r_state == RD_BURST) && w_last;
  assign w_wr_done = (r_state == WR_BURST) && w_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lat      <= '0;
      r_beat     <= '0;
      r_drop     <= 1'b0;
      r_rd_lines <= '0;
      r_wr_lines <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lat   <= w_lat_nxt;
      r_beat  <= w_beat_nxt;
      r_drop  <= addrstb && (r_state != IDLE);
      if (w_rd_done) r_rd_lines <= r_rd_lines + 16'd1;
      if (w_wr_done) r_wr_lines <= r_wr_lines + 16'd1;
    end
  end

  // A write beat sampled in the same cycle as a reset is still committed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_start <= addr[3 +: BEAT_W];
      r_line  <= line_of(addr);
    end
    if (r_state == WR_BURST) r_mem[w_word] <= data ^ init_word(w_word);
  end

  assign w_drive  = (r_state == RD_BURST);
  assign data     = w_drive ? w_rdata : 64'bz;
  assign stb      = (r_state == RD_BURST) || (r_state == WR_BURST);
  assign busy     = (r_state != IDLE);
  assign req_drop = r_drop;
  assign rd_lines = r_rd_lines;
  assign wr_lines = r_wr_lines;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: latency, beat order, write-back,
// dropped requests, reset mid-burst and line-index aliasing.
module tb_mem_line_responder;

  localparam int LB = 8;
  localparam int RL = 4;
  localparam int WL = 2;
  localparam logic [63:0] REL = '1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        addrstb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [63:0] tb_drv = '0;
  logic        tb_oe = 1'b0;
  logic        stb, busy, req_drop;
  logic [15:0] rd_lines, wr_lines;
  // Pulled-up bus: a released bus reads all-ones in 2- and 4-state simulators.
  tri1  [63:0] data;

  int vec = 0;
  int errs = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  assign data = tb_oe ? tb_drv : 64'bz;

  mem_line_responder #(
    .LINE_BEATS(LB), .MEM_WORDS(4096), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addrstb(addrstb), .we(we), .addr(addr),
    .data(data), .stb(stb), .busy(busy), .req_drop(req_drop),
    .rd_lines(rd_lines), .wr_lines(wr_lines)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int i);
    logic [31:0] u;
    u = i;
    return {u, ~u};
  endfunction

  // Issues one request from a negedge and runs its burst; returns at the negedge after the last beat.
  task automatic run_req(input logic w, input logic [31:0] a, input logic [7:0][63:0] wb,
                         output logic [7:0][63:0] rb, output int lat, output int gaps,
                         output int zbad, output bit to);
    rb = '0; lat = 0; gaps = 0; zbad = 0; to = 1'b0;
    addrstb = 1'b1; we = w; addr = a;
    @(negedge clk);
    addrstb = 1'b0;
    while (!stb && lat < 40) begin
      if (data !== REL) zbad++;
      @(negedge clk);
      lat++;
    end
    if (!stb) begin
      to = 1'b1;
      return;
    end
    for (int k = 0; k < LB; k++) begin
      if (!stb) gaps++;
      if (w) begin tb_oe = 1'b1; tb_drv = wb[k]; end
      else rb[k] = data;
      @(negedge clk);
    end
    tb_oe = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (stb !== 1'b0) begin errs++; $display("FAIL reset_stb: got %b want 0", stb); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (req_drop !== 1'b0) begin errs++; $display("FAIL reset_req_drop: got %b want 0", req_drop); end
    vec++; if (rd_lines !== 16'd0 || wr_lines !== 16'd0) begin
      errs++; $display("FAIL reset_counters: got rd=%0d wr=%0d want 0/0", rd_lines, wr_lines); end
    vec++; if (data !== REL) begin errs++; $display("FAIL reset_bus: got %h want released", data); end
    rst_n = 1'b1;
  endtask

  task automatic test_read_basic();
    logic [7:0][63:0] rb; int lat, gaps, zbad; bit to;
    run_req(1'b0, 32'h0000_0040, '0, rb, lat, gaps, zbad, to);
    exp_rd++;
    vec++; if (to) begin errs++; $display("FAIL rd_basic_timeout: no stb within budget"); end
    vec++; if (lat != RL) begin errs++; $display("FAIL rd_basic_latency: got %0d want %0d", lat, RL); end
    vec++; if (gaps != 0) begin errs++; $display("FAIL rd_basic_gaps: got %0d want 0", gaps); end
    vec++; if (zbad != 0) begin errs++; $display("FAIL rd_basic_wait_bus: %0d driven wait cycles want 0", zbad); end
    vec++; if (rb[0] !== {32'h8, 32'hFFFF_FFF7}) begin
      errs++; $display("FAIL rd_basic_word8: got %h want 00000008fffffff7", rb[0]); end
    for (int k = 0; k < LB; k++) begin
      vec++; if (rb[k] !== pat(8 + k)) begin
        errs++; $display("FAIL rd_basic_beat%0d: got %h want %h", k, rb[k], pat(8 + k)); end
    end
    vec++; if (rd_lines !== 16'(exp_rd)) begin errs++; $display("FAIL rd_basic_count: got %0d want %0d", rd_lines, exp_rd); end
    vec++; if (busy !== 1'b0 || stb !== 1'b0) begin
      errs++; $display("FAIL rd_basic_end: got busy=%b stb=%b want 0/0", busy, stb); end
    vec++; if (data !== REL) begin errs++; $display("FAIL rd_basic_release: got %h want released", data); end
  endtask

  task automatic test_read_wrap();
    logic [7:0][63:0] rb; int lat, gaps, zbad; bit to;
    int ord [8] = '{13, 14, 15, 8, 9, 10, 11, 12};
    vec++; if (data !== REL) begin errs++; $display("FAIL rd_wrap_pre_bus: got %h want released", data); end
    run_req(1'b0, 32'h0000_0068, '0, rb, lat, gaps, zbad, to);
    exp_rd++;
    vec++; if (to || gaps != 0 || zbad != 0) begin
      errs++; $display("FAIL rd_wrap_shape: got to=%0d gaps=%0d zbad=%0d want 0/0/0", to, gaps, zbad); end
    for (int k = 0; k < LB; k++) begin
      vec++; if (rb[k] !== pat(ord[k])) begin
        errs++; $display("FAIL rd_wrap_beat%0d: got %h want %h", k, rb[k], pat(ord[k])); end
    end
    vec++; if (data !== REL) begin errs++; $display("FAIL rd_wrap_release: got %h want released", data); end
    vec++; if (rd_lines !== 16'(exp_rd)) begin errs++; $display("FAIL rd_wrap_count: got %0d want %0d", rd_lines, exp_rd); end
  endtask

  task automatic test_write_readback();
    logic [7:0][63:0] wb, rb; int lat, gaps, zbad; bit to;
    do_reset();
    for (int k = 0; k < LB; k++) wb[k] = 64'hA0 + 64'(k);
    run_req(1'b1, 32'h0000_0080, wb, rb, lat, gaps, zbad, to);
    exp_wr++;
    vec++; if (to) begin errs++; $display("FAIL wr_timeout: no stb within budget"); end
    vec++; if (lat != WL) begin errs++; $display("FAIL wr_latency: got %0d want %0d", lat, WL); end
    vec++; if (gaps != 0 || zbad != 0) begin
      errs++; $display("FAIL wr_shape: got gaps=%0d zbad=%0d want 0/0", gaps, zbad); end
    vec++; if (data !== REL) begin errs++; $display("FAIL wr_release: got %h want released", data); end
    run_req(1'b0, 32'h0000_0080, '0, rb, lat, gaps, zbad, to);
    exp_rd++;
    for (int k = 0; k < LB; k++) begin
      vec++; if (rb[k] !== wb[k]) begin
        errs++; $display("FAIL wr_readback_beat%0d: got %h want %h", k, rb[k], wb[k]); end
    end
    vec++; if (wr_lines !== 16'd1 || rd_lines !== 16'd1) begin
      errs++; $display("FAIL wr_counts: got rd=%0d wr=%0d want 1/1", rd_lines, wr_lines); end
  endtask

  task automatic test_drop();
    logic [7:0][63:0] rb; int cnt, gaps, extra; logic d2, d3, d4;
    rb = '0; cnt = 0; gaps = 0; extra = 0; d2 = 1'b0; d3 = 1'b0; d4 = 1'b0;
    addrstb = 1'b1; we = 1'b0; addr = 32'h0000_0040;
    @(negedge clk);
    addrstb = 1'b0;
    while (!stb && cnt < 40) begin @(negedge clk); cnt++; end
    vec++; if (!stb) begin errs++; $display("FAIL drop_timeout: no stb within budget"); end
    for (int k = 0; k < LB; k++) begin
      if (!stb) gaps++;
      rb[k] = data;
      if (k == 2) begin d2 = req_drop; addrstb = 1'b1; we = 1'b1; addr = 32'h0000_0080; end
      if (k == 3) begin d3 = req_drop; addrstb = 1'b0; end
      if (k == 4) d4 = req_drop;
      if (k == 7) begin addrstb = 1'b1; we = 1'b0; addr = 32'h0000_0000; end
      @(negedge clk);
    end
    addrstb = 1'b0;
    exp_rd++;
    vec++; if (d2 !== 1'b0 || d3 !== 1'b1 || d4 !== 1'b0) begin
      errs++; $display("FAIL drop_pulse: got beat2=%b beat3=%b beat4=%b want 0/1/0", d2, d3, d4); end
    vec++; if (gaps != 0) begin errs++; $display("FAIL drop_gaps: got %0d want 0", gaps); end
    for (int k = 0; k < LB; k++) begin
      vec++; if (rb[k] !== pat(8 + k)) begin
        errs++; $display("FAIL drop_beat%0d: got %h want %h", k, rb[k], pat(8 + k)); end
    end
    vec++; if (req_drop !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL drop_last_beat: got req_drop=%b busy=%b want 1/0", req_drop, busy); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (stb || busy) extra++;
    end
    vec++; if (extra != 0) begin errs++; $display("FAIL drop_no_second: got %0d active cycles want 0", extra); end
    vec++; if (rd_lines !== 16'(exp_rd) || wr_lines !== 16'(exp_wr)) begin
      errs++; $display("FAIL drop_counts: got rd=%0d wr=%0d want %0d/%0d", rd_lines, wr_lines, exp_rd, exp_wr); end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0][63:0] rb; logic [63:0] expv; int cnt, lat, gaps, zbad; bit to;
    cnt = 0;
    addrstb = 1'b1; we = 1'b1; addr = 32'h0000_00C0;
    @(negedge clk);
    addrstb = 1'b0;
    while (!stb && cnt < 40) begin @(negedge clk); cnt++; end
    vec++; if (!stb) begin errs++; $display("FAIL rstw_timeout: no stb within budget"); end
    for (int k = 0; k < 4; k++) begin
      tb_oe = 1'b1; tb_drv = 64'hB0 + 64'(k);
      if (k == 3) rst_n = 1'b0;
      @(negedge clk);
    end
    tb_oe = 1'b0;
    #1;
    vec++; if (stb !== 1'b0 || busy !== 1'b0 || req_drop !== 1'b0) begin
      errs++; $display("FAIL rstw_outputs: got stb=%b busy=%b drop=%b want 0/0/0", stb, busy, req_drop); end
    vec++; if (rd_lines !== 16'd0 || wr_lines !== 16'd0) begin
      errs++; $display("FAIL rstw_counters: got rd=%0d wr=%0d want 0/0", rd_lines, wr_lines); end
    vec++; if (data !== REL) begin errs++; $display("FAIL rstw_bus: got %h want released", data); end
    rst_n = 1'b1;
    exp_rd = 0; exp_wr = 0;
    run_req(1'b0, 32'h0000_00C0, '0, rb, lat, gaps, zbad, to);
    exp_rd++;
    for (int k = 0; k < LB; k++) begin
      expv = (k < 4) ? 64'hB0 + 64'(k) : pat(24 + k);
      vec++; if (rb[k] !== expv) begin
        errs++; $display("FAIL rstw_readback_beat%0d: got %h want %h", k, rb[k], expv); end
    end
    vec++; if (rd_lines !== 16'd1 || wr_lines !== 16'd0) begin
      errs++; $display("FAIL rstw_counts: got rd=%0d wr=%0d want 1/0", rd_lines, wr_lines); end
  endtask

  task automatic test_alias();
    logic [7:0][63:0] rb0, rb1, rb2; int lat, gaps, zbad; bit to;
    run_req(1'b0, 32'h0000_0000, '0, rb0, lat, gaps, zbad, to);
    run_req(1'b0, 32'h0000_8000, '0, rb1, lat, gaps, zbad, to);
    run_req(1'b0, 32'h0000_801B, '0, rb2, lat, gaps, zbad, to);
    exp_rd += 3;
    for (int k = 0; k < LB; k++) begin
      vec++; if (rb1[k] !== pat(k) || rb1[k] !== rb0[k]) begin
        errs++; $display("FAIL alias_line512_beat%0d: got %h want %h", k, rb1[k], pat(k)); end
      vec++; if (rb2[k] !== pat((3 + k) % LB)) begin
        errs++; $display("FAIL alias_cwf_beat%0d: got %h want %h", k, rb2[k], pat((3 + k) % LB)); end
    end
    vec++; if (rd_lines !== 16'(exp_rd)) begin errs++; $display("FAIL alias_count: got %0d want %0d", rd_lines, exp_rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0][63:0] wb, rb; int lat, gaps, zbad; bit to;
    for (int k = 0; k < LB; k++) wb[k] = 64'h5A5A_0000_0000_00C0 + 64'(k);
    run_req(1'b1, 32'h0000_0100, wb, rb, lat, gaps, zbad, to);
    exp_wr++;
    run_req(1'b0, 32'h0000_0100, '0, rb, lat, gaps, zbad, to);
    exp_rd++;
    vec++; if (to || lat != RL || gaps != 0) begin
      errs++; $display("FAIL b2b_read_shape: got to=%0d lat=%0d gaps=%0d want 0/%0d/0", to, lat, gaps, RL); end
    for (int k = 0; k < LB; k++) begin
      vec++; if (rb[k] !== wb[k]) begin
        errs++; $display("FAIL b2b_beat%0d: got %h want %h", k, rb[k], wb[k]); end
    end
    vec++; if (rd_lines !== 16'(exp_rd) || wr_lines !== 16'(exp_wr)) begin
      errs++; $display("FAIL b2b_counts: got rd=%0d wr=%0d want %0d/%0d", rd_lines, wr_lines, exp_rd, exp_wr); end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_wrap();
    test_write_readback();
    test_drop();
    test_reset_mid_write();
    test_alias();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
